// File: rtl/vliw_bundle_imem.sv
// ---------------------------------------------------------------------------
// vliw_bundle_imem
//   Writable instruction memory for the VLIW fetch stage. Each of the DEPTH
//   entries holds one bundle: {wide slot (W_WIDE bits), compressed slot
//   (W_NARR bits)}. A program port loads bundles at runtime. The fetch side
//   uses a valid/ready handshake with a single registered response, which
//   gives one-cycle latency and full throughput while decode keeps up.
//
// Ports
//   clk, reset               rising-edge clock, async active-low reset
//   prog_we/addr/data/lock   program port; a write is ignored while prog_lock=1
//   req_valid/ready/addr     fetch request handshake (bundle index)
//   resp_valid/ready         response handshake towards decode
//   resp_addr                address of the returned bundle
//   resp_wide/resp_narr      wide and compressed slot of the bundle
//   resp_unwr                entry never written since reset (data reads as 0)
//   resp_badenc              slot-encoding check failed (written entries only)
// ---------------------------------------------------------------------------
module vliw_bundle_imem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W_WIDE = 32,
  parameter int W_NARR = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [W_WIDE+W_NARR-1:0] prog_data,
  input  logic                     prog_lock,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ADDR_W-1:0]        resp_addr,
  output logic [W_WIDE-1:0]        resp_wide,
  output logic [W_NARR-1:0]        resp_narr,
  output logic                     resp_unwr,
  output logic                     resp_badenc
);

  localparam int W_BUN = W_WIDE + W_NARR;

  logic [W_BUN-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic              prog_en;
  logic              accept;
  logic              bypass;
  logic              rd_written;
  logic [W_BUN-1:0]  rd_data;
  logic [W_WIDE-1:0] rd_wide;
  logic [W_NARR-1:0] rd_narr;
  logic              rd_badenc;

  assign prog_en   = prog_we & ~prog_lock;
  // Single output register with no skid buffer: a new request can only be
  // taken when the register is empty or is being drained this cycle.
  assign req_ready = ~resp_valid | resp_ready;
  assign accept    = req_valid & req_ready;

  // NOTE: the storage array has no reset. Clearing the written flags is
  // enough: every read of an unwritten entry is forced to zero below, so the
  // array is observably cleared without a reset network on every bit.
  always_ff @(posedge clk) begin
    if (prog_en) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      written <= '0;
    end else if (prog_en) begin
      written[prog_addr] <= 1'b1;
    end
  end

  // Read path with write-through bypass: a fetch on the same edge as an
  // unlocked write to the same entry sees the new bundle.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_data    = '0;
    bypass     = prog_en && (prog_addr == req_addr);
    rd_written = bypass | written[req_addr];
    if (bypass) begin
      rd_data = prog_data;
    end else if (written[req_addr]) begin
      rd_data = mem[req_addr];
    end
  end

  assign rd_wide = rd_data[W_BUN-1:W_NARR];
  assign rd_narr = rd_data[W_NARR-1:0];
  // Wide slot must carry the 32-bit opcode marker (low bits 11); the
  // compressed slot must not. Unwritten entries are never flagged.
  assign rd_badenc = rd_written &
                     ((rd_wide[1:0] != 2'b11) | (rd_narr[1:0] == 2'b11));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid  <= 1'b0;
      resp_addr   <= '0;
      resp_wide   <= '0;
      resp_narr   <= '0;
      resp_unwr   <= 1'b0;
      resp_badenc <= 1'b0;
    end else if (accept) begin
      resp_valid  <= 1'b1;
      resp_addr   <= req_addr;
      resp_wide   <= rd_wide;
      resp_narr   <= rd_narr;
      resp_unwr   <= ~rd_written;
      resp_badenc <= rd_badenc;
    end else if (resp_ready) begin
      // Drained with nothing new behind it; payload fields just hold.
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vliw_bundle_imem.sv
// ---------------------------------------------------------------------------
// tb_vliw_bundle_imem
//   Scoreboard bench for vliw_bundle_imem. A reference model (plain arrays
//   holding bundle contents and written flags) predicts each accepted fetch
//   and pushes the expected response into a queue; a monitor on the falling
//   edge compares the presented response against the queue head and pops it
//   when decode consumes it. Directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_vliw_bundle_imem;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wide;
    logic [15:0] narr;
    logic        unwr;
    logic        bad;
  } resp_t;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [47:0] prog_data;
  logic        prog_lock;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_addr;
  logic [31:0] resp_wide;
  logic [15:0] resp_narr;
  logic        resp_unwr;
  logic        resp_badenc;

  vliw_bundle_imem #(.DEPTH(16), .ADDR_W(4), .W_WIDE(32), .W_NARR(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_lock  (prog_lock),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_addr  (resp_addr),
    .resp_wide  (resp_wide),
    .resp_narr  (resp_narr),
    .resp_unwr  (resp_unwr),
    .resp_badenc(resp_badenc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [47:0] ref_mem [16];
  bit          ref_wr  [16];
  resp_t       sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      ref_wr[i]  = 1'b0;
    end
  endtask

  // Monitor + model step, evaluated mid-cycle so inputs and outputs are
  // stable. Pending responses are at most one (single output register).
  always @(negedge clk) begin
    if (reset) begin
      bit    exp_v;
      resp_t e;
      exp_v = (sb.size() != 0);
      check("resp_valid", 64'(resp_valid), 64'(exp_v));
      check("req_ready", 64'(req_ready), 64'(!exp_v || resp_ready));
      if (exp_v && resp_valid) begin
        e = sb[0];
        check("resp_addr",   64'(resp_addr),   64'(e.addr));
        check("resp_wide",   64'(resp_wide),   64'(e.wide));
        check("resp_narr",   64'(resp_narr),   64'(e.narr));
        check("resp_unwr",   64'(resp_unwr),   64'(e.unwr));
        check("resp_badenc", 64'(resp_badenc), 64'(e.bad));
      end
      if (exp_v && resp_ready) void'(sb.pop_front());
      // A write lands before the same-edge read sees memory.
      if (prog_we && !prog_lock) begin
        ref_mem[prog_addr] = prog_data;
        ref_wr[prog_addr]  = 1'b1;
      end
      if (req_valid && (!exp_v || resp_ready)) begin
        e.addr = req_addr;
        e.unwr = !ref_wr[req_addr];
        e.wide = ref_wr[req_addr] ? ref_mem[req_addr][47:16] : 32'h0;
        e.narr = ref_wr[req_addr] ? ref_mem[req_addr][15:0]  : 16'h0;
        e.bad  = ref_wr[req_addr] && ((e.wide[1:0] != 2'b11) || (e.narr[1:0] == 2'b11));
        sb.push_back(e);
      end
    end
  end

  // Apply one cycle of stimulus, then advance to just after the next edge.
  task automatic drive(input bit pwe, input logic [3:0] pa, input logic [47:0] pd,
                       input bit pl, input bit rv, input logic [3:0] ra, input bit rr);
    prog_we    = pwe;
    prog_addr  = pa;
    prog_data  = pd;
    prog_lock  = pl;
    req_valid  = rv;
    req_addr   = ra;
    resp_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] ra);
    drive(0, 0, 0, 0, 1, ra, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b0;
    model_clear();
    prog_we = 0; prog_addr = 0; prog_data = 0; prog_lock = 0;
    req_valid = 0; req_addr = 0; resp_ready = 1;

    // 1: reset state, then fetch of an unwritten entry
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_resp_valid",  64'(resp_valid),  64'(0));
    check("rst_req_ready",   64'(req_ready),   64'(1));
    check("rst_resp_addr",   64'(resp_addr),   64'(0));
    check("rst_resp_wide",   64'(resp_wide),   64'(0));
    check("rst_resp_narr",   64'(resp_narr),   64'(0));
    check("rst_resp_unwr",   64'(resp_unwr),   64'(0));
    check("rst_resp_badenc", 64'(resp_badenc), 64'(0));
    reset = 1'b1;
    fetch(3);
    idle(2);

    // 2: program and fetch a well-formed bundle
    drive(1, 0, {32'h001080B3, 16'h8316}, 0, 0, 0, 1);
    fetch(0);
    idle(2);

    // 3: same-edge write and fetch of addr 5 (bypass)
    drive(1, 5, 48'h00F0_0293_4529, 0, 1, 5, 1);
    idle(2);

    // 4: decode stalls three cycles with a second request waiting
    drive(1, 1, 48'h1111_1113_2222, 0, 0, 0, 1);
    drive(1, 2, 48'h3333_3337_4444, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 2, 0);
    drive(0, 0, 0, 0, 1, 2, 1);
    idle(2);

    // 5: locked write is dropped; bad encoding flagged
    drive(1, 7, 48'hFFFF_FFFF_FFFF, 1, 0, 0, 1);
    fetch(7);
    drive(1, 8, {32'h00000000, 16'h0003}, 0, 0, 0, 1);
    fetch(8);
    drive(1, 9, 48'hFFFF_FFFF_FFFF, 1, 1, 9, 1);   // locked, same-edge: no bypass
    idle(2);

    // 6: stream 14,15,0 then reset mid-stream
    fetch(14);
    fetch(15);
    fetch(0);
    reset = 1'b0;
    model_clear();
    #1;
    check("midrst_resp_valid", 64'(resp_valid), 64'(0));
    check("midrst_req_ready",  64'(req_ready),  64'(1));
    drive(0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    fetch(0);                                        // contents lost -> unwritten
    idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [47:0] d;
      d = {$urandom(), 16'($urandom())};
      if ($urandom_range(0, 3) != 0) begin
        d[17:16] = 2'b11;
        d[1:0]   = 2'($urandom_range(0, 2));
      end
      drive($urandom_range(0, 9) < 3, 4'($urandom()), d, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, 4'($urandom()), $urandom_range(0, 3) != 0);
    end
    idle(4);
    check("drain_pending", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
